// File: rtl/bcd_pkg.sv
// Shared types and constants for the four-digit BCD stopwatch.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  typedef logic [3:0] digit_t;

  localparam digit_t BCD_MAX   = 4'd9;
  localparam digit_t BCD_BLANK = 4'hF;

endpackage

// File: rtl/bcd_digit.sv
// Single decade counter: counts 0..9, emits a combinational carry when
// incremented at 9 so several instances can be chained into a ripple counter.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   clr_i,
  input  logic   inc_i,
  output digit_t value_o,
  output logic   carry_o
);

  digit_t value_q;
  digit_t value_d;

  assign carry_o = inc_i && (value_q == BCD_MAX);
  assign value_o = value_q;

  // Next value: clear dominates, otherwise wrap 9 -> 0 on increment.
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i) begin
      value_d = (value_q == BCD_MAX) ? '0 : value_q + 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit decimal stopwatch with start/stop and clear keys (active-low,
// asynchronous). Keys are synchronized, edge-detected to one-cycle press
// pulses, and drive an IDLE/RUN/PAUSE FSM. A prescaler divides CLOCK_50 down
// to the count tick. Optional macro LEADING_ZERO_BLANK_EN replaces leading
// zero digits (dig3..dig1) with 4'hF so the segment decoder blanks them.
module bcd_stopwatch
  import bcd_pkg::*;
#(
  parameter int TICK_DIV    = 5000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       running,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  typedef logic [PW-1:0] presc_t;
  localparam presc_t PRESC_LAST = presc_t'(TICK_DIV - 1);

  logic [SYNC_STAGES-1:0] start_sync_q;
  logic [SYNC_STAGES-1:0] clear_sync_q;
  logic                   start_prev_q;
  logic                   clear_prev_q;
  logic                   start_pulse;
  logic                   clear_pulse;

  state_e state_q;
  state_e state_d;
  presc_t presc_q;
  presc_t presc_d;
  logic   tick;
  logic   digits_clr;
  logic   wrap_q;

  digit_t     cnt [4];
  logic [4:0] carry;

  // Key synchronizers and edge-detect history; preset to released so reset never fakes a press.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      start_sync_q <= '1;
      clear_sync_q <= '1;
      start_prev_q <= 1'b1;
      clear_prev_q <= 1'b1;
    end else begin
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], key_start_n};
      clear_sync_q <= {clear_sync_q[SYNC_STAGES-2:0], key_clear_n};
      start_prev_q <= start_sync_q[SYNC_STAGES-1];
      clear_prev_q <= clear_sync_q[SYNC_STAGES-1];
    end
  end

  assign start_pulse = start_prev_q & ~start_sync_q[SYNC_STAGES-1];
  assign clear_pulse = clear_prev_q & ~clear_sync_q[SYNC_STAGES-1];

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; in PAUSE clear outranks start, elsewhere clear is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_pulse) state_d = S_RUN;
      S_RUN:   if (start_pulse) state_d = S_PAUSE;
      S_PAUSE: begin
        if (clear_pulse)      state_d = S_IDLE;
        else if (start_pulse) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: running follows the registered state directly.
  always_comb begin
    running    = (state_q == S_RUN);
    digits_clr = (state_q == S_PAUSE) && clear_pulse;
  end

  assign tick = (state_q == S_RUN) && (presc_q == PRESC_LAST);

  // Prescaler next value: counts in RUN, holds in PAUSE, zero elsewhere or on clear.
  always_comb begin
    presc_d = presc_q;
    case (state_q)
      S_RUN:   presc_d = tick ? '0 : presc_q + presc_t'(1);
      S_PAUSE: if (clear_pulse) presc_d = '0;
      default: presc_d = '0;
    endcase
  end

  // Prescaler register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign carry[0] = tick;

  for (genvar g = 0; g < 4; g++) begin : g_dig
    bcd_digit u_dig (
      .clk_i   (CLOCK_50),
      .rst_i   (reset),
      .clr_i   (digits_clr),
      .inc_i   (carry[g]),
      .value_o (cnt[g]),
      .carry_o (carry[g+1])
    );
  end

  // Wrap pulse lines up with the cycle the display first shows 0000.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= carry[4];
    end
  end

  assign wrap = wrap_q;

  // Display mux straight off the registered digit counters.
  always_comb begin
    dig0 = cnt[0];
`ifdef LEADING_ZERO_BLANK_EN
    dig3 = (cnt[3] == 4'd0) ? BCD_BLANK : cnt[3];
    dig2 = ((cnt[3] == 4'd0) && (cnt[2] == 4'd0)) ? BCD_BLANK : cnt[2];
    dig1 = ((cnt[3] == 4'd0) && (cnt[2] == 4'd0) && (cnt[1] == 4'd0)) ? BCD_BLANK : cnt[1];
`else
    dig3 = cnt[3];
    dig2 = cnt[2];
    dig1 = cnt[1];
`endif
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch: integer-level reference model checked
// every cycle, directed scenarios with literal expectations, random key traffic.
module tb_bcd_stopwatch;

  localparam int TD = 4;
  localparam int SS = 2;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [15:0] L0000 = 16'hFFF0;
  localparam logic [15:0] L0001 = 16'hFFF1;
  localparam logic [15:0] L0010 = 16'hFF10;
  localparam logic [15:0] L0037 = 16'hFF37;
  localparam logic [15:0] L0042 = 16'hFF42;
`else
  localparam logic [15:0] L0000 = 16'h0000;
  localparam logic [15:0] L0001 = 16'h0001;
  localparam logic [15:0] L0010 = 16'h0010;
  localparam logic [15:0] L0037 = 16'h0037;
  localparam logic [15:0] L0042 = 16'h0042;
`endif
  localparam logic [15:0] L9999 = 16'h9999;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       key_start_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic       running, wrap;

  int checks = 0;
  int failures = 0;

  bcd_stopwatch #(.TICK_DIV(TD), .SYNC_STAGES(SS)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .key_start_n (key_start_n),
    .key_clear_n (key_clear_n),
    .dig0        (dig0),
    .dig1        (dig1),
    .dig2        (dig2),
    .dig3        (dig3),
    .running     (running),
    .wrap        (wrap)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model: count as an integer 0..9999, state 0=IDLE 1=RUN 2=PAUSE.
  int m_count = 0;
  int m_state = 0;
  int m_presc = 0;
  bit m_wrap  = 0;
  // Key levels sampled at the previous three edges (s1 newest).
  bit s1 = 1, s2 = 1, s3 = 1;
  bit c1 = 1, c2 = 1, c3 = 1;

  function automatic logic [15:0] disp(input int n);
    int d0, d1, d2, d3;
    logic [15:0] r;
    d0 = n % 10;
    d1 = (n / 10) % 10;
    d2 = (n / 100) % 10;
    d3 = (n / 1000) % 10;
    r = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
`ifdef LEADING_ZERO_BLANK_EN
    if (d3 == 0) r[15:12] = 4'hF;
    if (d3 == 0 && d2 == 0) r[11:8] = 4'hF;
    if (d3 == 0 && d2 == 0 && d1 == 0) r[7:4] = 4'hF;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLOCK_50) begin
    bit sp, cp, tk;
    if (reset) begin
      m_count = 0; m_state = 0; m_presc = 0; m_wrap = 0;
      s1 = 1; s2 = 1; s3 = 1;
      c1 = 1; c2 = 1; c3 = 1;
    end else begin
      // A press acts on the edge three samples after the key was last seen released.
      sp = s3 && !s2;
      cp = c3 && !c2;
      tk = (m_state == 1) && (m_presc == TD - 1);
      m_wrap = tk && (m_count == 9999);
      if (m_state == 1) begin
        m_presc = tk ? 0 : m_presc + 1;
        if (tk) m_count = (m_count + 1) % 10000;
      end
      case (m_state)
        0: if (sp) begin m_state = 1; m_presc = 0; end
        1: if (sp) m_state = 2;
        default: begin
          if (cp) begin m_state = 0; m_count = 0; m_presc = 0; end
          else if (sp) m_state = 1;
        end
      endcase
      s3 = s2; s2 = s1; s1 = key_start_n;
      c3 = c2; c2 = c1; c1 = key_clear_n;
    end
    #1;
    check("digits", {dig3, dig2, dig1, dig0}, disp(m_count));
    check("running", {15'd0, running}, {15'd0, (m_state == 1)});
    check("wrap", {15'd0, wrap}, {15'd0, m_wrap});
  end

  task automatic tap(input bit st, input bit cl);
    @(negedge CLOCK_50);
    if (st) key_start_n = 1'b0;
    if (cl) key_clear_n = 1'b0;
    @(negedge CLOCK_50);
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
  endtask

  task automatic hold(input bit st, input bit cl, input int n);
    @(negedge CLOCK_50);
    if (st) key_start_n = 1'b0;
    if (cl) key_clear_n = 1'b0;
    repeat (n) @(negedge CLOCK_50);
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
  endtask

  task automatic wait_count(input int n, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge CLOCK_50);
      #2;
      if (m_count == n) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wait_count got=%0d exp=%0d", m_count, n);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    check("rst_digits", {dig3, dig2, dig1, dig0}, L0000);
    check("rst_running", {15'd0, running}, 16'd0);
    check("rst_wrap", {15'd0, wrap}, 16'd0);

    // Start press latency and first ticks.
    @(negedge CLOCK_50) key_start_n = 1'b0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50) key_start_n = 1'b1;
    @(posedge CLOCK_50); #1;
    check("lat_edge2", {15'd0, running}, 16'd0);
    @(posedge CLOCK_50); #1;
    check("lat_edge3", {15'd0, running}, 16'd1);
    repeat (4) @(posedge CLOCK_50); #1;
    check("count_0001", {dig3, dig2, dig1, dig0}, L0001);
    repeat (36) @(posedge CLOCK_50); #1;
    check("count_0010", {dig3, dig2, dig1, dig0}, L0010);

    wait_count(42, 400);
    check("count_0042", {dig3, dig2, dig1, dig0}, L0042);

    // Reset in the middle of counting.
    wait_count(512, 3000);
    @(negedge CLOCK_50) reset = 1'b1;
    @(posedge CLOCK_50); #1;
    check("midrst_digits", {dig3, dig2, dig1, dig0}, L0000);
    check("midrst_running", {15'd0, running}, 16'd0);
    @(negedge CLOCK_50) reset = 1'b0;

    // Run up to the 9999 -> 0000 rollover.
    tap(1, 0);
    wait_count(9998, 45000);
    repeat (4) @(posedge CLOCK_50); #1;
    check("count_9999", {dig3, dig2, dig1, dig0}, L9999);
    check("wrap_before", {15'd0, wrap}, 16'd0);
    repeat (4) @(posedge CLOCK_50); #1;
    check("rollover", {dig3, dig2, dig1, dig0}, L0000);
    check("wrap_pulse", {15'd0, wrap}, 16'd1);
    check("wrap_running", {15'd0, running}, 16'd1);
    @(posedge CLOCK_50); #1;
    check("wrap_after", {15'd0, wrap}, 16'd0);

    // Pause at 0037, then clear.
    wait_count(37, 400);
    tap(1, 0);
    repeat (100) @(posedge CLOCK_50); #1;
    check("pause_frozen", {dig3, dig2, dig1, dig0}, L0037);
    check("pause_running", {15'd0, running}, 16'd0);
    tap(0, 1);
    repeat (5) @(posedge CLOCK_50); #1;
    check("clear_digits", {dig3, dig2, dig1, dig0}, L0000);
    check("clear_running", {15'd0, running}, 16'd0);

    // Clear held in RUN is ignored; start held gives one transition.
    tap(1, 0);
    repeat (10) @(posedge CLOCK_50);
    hold(0, 1, 50);
    repeat (5) @(posedge CLOCK_50); #1;
    check("clear_in_run", {15'd0, running}, 16'd1);
    hold(1, 0, 50);
    repeat (5) @(posedge CLOCK_50); #1;
    check("start_held", {15'd0, running}, 16'd0);

    // Both keys together: PAUSE -> IDLE, then RUN -> PAUSE.
    tap(1, 1);
    repeat (5) @(posedge CLOCK_50); #1;
    check("both_pause", {dig3, dig2, dig1, dig0}, L0000);
    check("both_pause_run", {15'd0, running}, 16'd0);
    tap(1, 0);
    repeat (30) @(posedge CLOCK_50);
    tap(1, 1);
    repeat (5) @(posedge CLOCK_50); #1;
    check("both_run", {15'd0, running}, 16'd0);

    // Random key traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLOCK_50);
      if ($urandom_range(0, 7) == 0) key_start_n = ~key_start_n;
      if ($urandom_range(0, 9) == 0) key_clear_n = ~key_clear_n;
      reset = ($urandom_range(0, 599) == 0);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (5) @(posedge CLOCK_50);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
